// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles the three buses seen by mem_bus_arbiter:
//     - instruction-fetch requester: if_req/if_addr in, if_rdata/if_ack out
//     - data (load/store) requester: dm_req/dm_we/dm_sel/dm_addr/dm_wdata in,
//       dm_rdata/dm_ack out
//     - single-port synchronous memory: mem_ce/mem_we/mem_sel/mem_addr/
//       mem_wdata out, mem_rdata in
//     - stallreq_o to the pipeline controller
//   Modports:
//     slave  : the arbiter's view (requests in, acks and memory controls out)
//     master : the surrounding system's view (requesters, memory, controller)
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_sel;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    logic              mem_ce;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stallreq_o;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_rdata, if_ack,
        output dm_rdata, dm_ack,
        output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
        output stallreq_o
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_rdata, if_ack,
        input  dm_rdata, dm_ack,
        input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
        input  stallreq_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one single-port synchronous memory between the instruction-fetch
//   port and the load/store port of the core. Each access runs
//   IDLE -> ISSUE -> WAIT -> DONE: the winner's attributes are registered in
//   IDLE, mem_ce pulses in ISSUE, WAIT counts MEM_LAT cycles and captures
//   mem_rdata, DONE pulses the owner's ack.
//   The data port wins ties, except that after two data grants taken while a
//   fetch was waiting, the fetch wins the next arbitration.
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - synchronous reset, active-high; abandons any access in flight
//   bus  - mem_bus_arbiter_if.slave (fetch port, data port, memory port,
//          stallreq_o)
// Parameters:
//   ADDR_W, DATA_W - bus widths
//   MEM_LAT        - cycles from mem_ce to valid mem_rdata, 1..4
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    logic              grant_dm;
    logic              grant_if;
    logic [1:0]        fair_cnt;
    logic [2:0]        lat_cnt;

    logic              mem_we_q;
    logic [3:0]        mem_sel_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ack;
    logic              dm_ack;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and arbitration decision.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next = state;
        grant_dm   = 1'b0;
        grant_if   = 1'b0;
        unique case (state)
            IDLE: begin
                // Data port wins unless a fetch has already waited through
                // two data grants.
                if (bus.dm_req && !(bus.if_req && fair_cnt == 2'd2)) begin
                    grant_dm   = 1'b1;
                    state_next = ISSUE;
                end else if (bus.if_req) begin
                    grant_if   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            // lat_cnt == 1 is the cycle in which the decrement reaches zero.
            WAIT:    if (lat_cnt == 3'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: memory attributes, fairness, latency and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= OWN_IF;
            fair_cnt    <= 2'd0;
            lat_cnt     <= 3'd0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if (grant_dm) begin
                owner       <= OWN_DM;
                mem_we_q    <= bus.dm_we;
                mem_sel_q   <= bus.dm_sel;
                mem_addr_q  <= bus.dm_addr;
                mem_wdata_q <= bus.dm_wdata;
                if (bus.if_req && fair_cnt != 2'd2) fair_cnt <= fair_cnt + 2'd1;
            end else if (grant_if) begin
                // Fetches are always full-word reads.
                owner       <= OWN_IF;
                mem_we_q    <= 1'b0;
                mem_sel_q   <= 4'b1111;
                mem_addr_q  <= bus.if_addr;
                mem_wdata_q <= '0;
                fair_cnt    <= 2'd0;
            end

            if (state == ISSUE) begin
                lat_cnt <= 3'(MEM_LAT);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
                if (lat_cnt == 3'd1) begin
                    if (owner == OWN_IF)  if_rdata_q <= bus.mem_rdata;
                    else if (!mem_we_q)   dm_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign if_ack = (state == DONE) && (owner == OWN_IF);
    assign dm_ack = (state == DONE) && (owner == OWN_DM);

    assign bus.if_ack     = if_ack;
    assign bus.dm_ack     = dm_ack;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.dm_rdata   = dm_rdata_q;
    assign bus.mem_ce     = (state == ISSUE);
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_sel    = mem_sel_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.stallreq_o = (bus.if_req & ~if_ack) | (bus.dm_req & ~dm_ack);
endmodule
